// File: rtl/pe_multicast_controller.sv
// Tag-matching front end for one PE: accepts bus packets addressed to this PE's
// ID (or the broadcast tag), queues them, and forwards them under pe_ready.
module pe_multicast_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int TAG_BIT    = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_BIT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_id,
   input  logic [TAG_BIT-1:0]    id_in,
   input  logic [TAG_BIT-1:0]    tag_in,
   input  logic [DATA_WIDTH:0]   data_in,
   output logic                  data_ready,
   output logic [DATA_WIDTH:0]   data_out,
   input  logic                  pe_ready,
   output logic                  configured,
   output logic [CNT_BIT-1:0]    match_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [TAG_BIT-1:0] BCAST_TAG  = '1;
   localparam logic [AW:0]        FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [TAG_BIT-1:0]    id_reg;
   logic                  configured_reg;
   logic [AW-1:0]         head_reg;
   logic [AW-1:0]         tail_reg;
   logic [AW:0]           count_reg;
   logic [AW:0]           count_next;
   logic [CNT_BIT-1:0]    match_cnt_reg;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic                  pkt_enable;
   logic [DATA_WIDTH-1:0] pkt_payload;
   logic                  full;
   logic                  empty;
   logic                  match;
   logic                  push;
   logic                  pop;

   assign pkt_enable  = data_in[DATA_WIDTH];
   assign pkt_payload = data_in[DATA_WIDTH-1:0];

   assign full  = (count_reg == FULL_COUNT);
   assign empty = (count_reg == '0);

   // Matching uses the registered ID, so a concurrent set_id only affects later packets.
   assign match = configured_reg && ((tag_in == id_reg) || (tag_in == BCAST_TAG));

   // Unaddressed or unconfigured traffic is always let through; only our own packets can stall.
   assign data_ready = !match || !full;

   assign push = pkt_enable && match && !full;
   assign pop  = !empty && pe_ready;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_reg         <= '0;
         configured_reg <= 1'b0;
      end else if (set_id && (id_in != BCAST_TAG)) begin
         id_reg         <= id_in;
         configured_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + AW'(1);
         end
         if (pop) begin
            head_reg <= head_reg + AW'(1);
         end
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt_reg <= '0;
      end else if (push) begin
         match_cnt_reg <= match_cnt_reg + CNT_BIT'(1);
      end
   end

   // Storage carries no reset; stale entries are never visible because data_out is gated by empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail_reg] <= pkt_payload;
      end
   end

   assign data_out   = empty ? '0 : {1'b1, mem[head_reg]};
   assign configured = configured_reg;
   assign match_cnt  = match_cnt_reg;

endmodule
